// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared constants and types for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int TAG_WIDTH_DEFAULT = 4;

    localparam logic [2:0] OPENUM_MUL    = 3'd0;
    localparam logic [2:0] OPENUM_MULH   = 3'd1;
    localparam logic [2:0] OPENUM_MULHSU = 3'd2;
    localparam logic [2:0] OPENUM_MULHU  = 3'd3;
    localparam logic [2:0] OPENUM_DIV    = 3'd4;
    localparam logic [2:0] OPENUM_DIVU   = 3'd5;
    localparam logic [2:0] OPENUM_REM    = 3'd6;
    localparam logic [2:0] OPENUM_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // funct3 bit 2 selects the divide group; within it bit 1 picks remainder
    // and bit 0 marks the unsigned variants.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[1];
    endfunction

    function automatic logic op_div_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_div_step
// Description : Combinational restoring-divide step retiring DIV_BITS bits.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit_div_step #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic [XLEN-1:0]     rem_in,
    input  logic [DIV_BITS-1:0] dvd_msb,
    input  logic [XLEN-1:0]     dvs_in,
    output logic [XLEN-1:0]     rem_out,
    output logic [DIV_BITS-1:0] quo_out
);

    always_comb begin
        logic [XLEN:0]   w_trial;
        logic [XLEN-1:0] w_rem;
        w_rem   = rem_in;
        w_trial = '0;
        quo_out = '0;
        for (int i = DIV_BITS - 1; i >= 0; i--) begin
            w_trial = {w_rem, dvd_msb[i]};
            if (w_trial >= {1'b0, dvs_in}) begin
                w_trial    = w_trial - {1'b0, dvs_in};
                quo_out[i] = 1'b1;
            end
            w_rem = w_trial[XLEN-1:0];
        end
        rem_out = w_rem;
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle RV32M multiply/divide unit with flush and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
    parameter int DIV_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [XLEN-1:0]      in_v1,
    input  logic [XLEN-1:0]      in_v2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 busy
);

    localparam int                 STEPS    = XLEN / DIV_BITS;
    localparam int                 CNT_W    = $clog2(STEPS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]    MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [XLEN-1:0]        a_q, a_d;
    logic [XLEN-1:0]        b_q, b_d;
    logic [XLEN-1:0]        rem_q, rem_d;
    logic [XLEN-1:0]        result_q, result_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;

    // Accept-time operand conditioning for the divide path
    logic                   w_v1_neg, w_v2_neg, w_div_zero, w_div_ovf;
    logic [XLEN-1:0]        w_abs_v1, w_abs_v2;

    assign w_v1_neg   = op_div_signed(in_op) & in_v1[XLEN-1];
    assign w_v2_neg   = op_div_signed(in_op) & in_v2[XLEN-1];
    assign w_abs_v1   = w_v1_neg ? (~in_v1 + 1'b1) : in_v1;
    assign w_abs_v2   = w_v2_neg ? (~in_v2 + 1'b1) : in_v2;
    assign w_div_zero = (in_v2 == '0);
    assign w_div_ovf  = op_div_signed(in_op) && (in_v1 == MOST_NEG) && (in_v2 == '1);

    // Multiplier: sign-extend to 2*XLEN so one unsigned product covers all variants
    logic                   w_mul_a_sx, w_mul_b_sx;
    logic [2*XLEN-1:0]      w_mul_a, w_mul_b, w_prod;
    logic [XLEN-1:0]        w_mul_res;

    assign w_mul_a_sx = ((op_q == OPENUM_MULH) || (op_q == OPENUM_MULHSU)) & a_q[XLEN-1];
    assign w_mul_b_sx = (op_q == OPENUM_MULH) & b_q[XLEN-1];
    assign w_mul_a    = {{XLEN{w_mul_a_sx}}, a_q};
    assign w_mul_b    = {{XLEN{w_mul_b_sx}}, b_q};
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_mul_res  = (op_q == OPENUM_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // a_q doubles as the dividend shift register; quotient bits enter at the bottom
    logic [XLEN-1:0]        w_rem_nxt, w_quo_nxt, w_quo_signed, w_rem_signed, w_div_res;
    logic [DIV_BITS-1:0]    w_q_bits;

    muldiv_unit_div_step #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_div_step (
        .rem_in  (rem_q),
        .dvd_msb (a_q[XLEN-1 -: DIV_BITS]),
        .dvs_in  (b_q),
        .rem_out (w_rem_nxt),
        .quo_out (w_q_bits)
    );

    assign w_quo_nxt    = {a_q[XLEN-DIV_BITS-1:0], w_q_bits};
    assign w_quo_signed = neg_quo_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_rem_signed = neg_rem_q ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_div_res    = op_is_rem(op_q) ? w_rem_signed : w_quo_signed;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        result_d  = result_q;
        tag_d     = tag_q;
        count_d   = count_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (rdy_in) begin
            if (clear_in) begin
                state_d = ST_IDLE;
                count_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (in_valid) begin
                            op_d    = in_op;
                            tag_d   = in_tag;
                            count_d = '0;
                            rem_d   = '0;
                            if (!op_is_div(in_op)) begin
                                a_d     = in_v1;
                                b_d     = in_v2;
                                state_d = ST_MUL;
                            end else if (w_div_zero) begin
                                result_d = op_is_rem(in_op) ? in_v1 : '1;
                                state_d  = ST_DONE;
                            end else if (w_div_ovf) begin
                                result_d = op_is_rem(in_op) ? '0 : in_v1;
                                state_d  = ST_DONE;
                            end else begin
                                a_d       = w_abs_v1;
                                b_d       = w_abs_v2;
                                neg_quo_d = w_v1_neg ^ w_v2_neg;
                                neg_rem_d = w_v1_neg;
                                state_d   = ST_DIV;
                            end
                        end
                    end
                    ST_MUL: begin
                        result_d = w_mul_res;
                        state_d  = ST_DONE;
                    end
                    ST_DIV: begin
                        rem_d   = w_rem_nxt;
                        a_d     = w_quo_nxt;
                        count_d = count_q + 1'b1;
                        if (count_q == CNT_LAST) begin
                            result_d = w_div_res;
                            count_d  = '0;
                            state_d  = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            count_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
            count_q   <= count_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench; DIV_BITS=1 and DIV_BITS=2 units in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, in_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] v1, v2;
    logic [3:0]  tag;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [31:0] a_out_result;
    logic [3:0]  a_out_tag;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [31:0] b_out_result;
    logic [3:0]  b_out_tag;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .TAG_WIDTH(4), .DIV_BITS(1)) u_dut_a (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_op(in_op),
        .in_v1(v1), .in_v2(v2), .in_tag(tag),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_result(a_out_result), .out_tag(a_out_tag), .busy(a_busy)
    );

    muldiv_unit #(.XLEN(32), .TAG_WIDTH(4), .DIV_BITS(2)) u_dut_b (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_op(in_op),
        .in_v1(v1), .in_v2(v2), .in_tag(tag),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_result(b_out_result), .out_tag(b_out_tag), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules, using 64-bit host arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        p  = '0;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int db);
        if (!op[2]) return 1;
        if (b == 0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32 / db;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Offers one op to both units, then measures latency and result of each.
    // stall_at >= 0 drops rdy for three cycles starting that many cycles after accept.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t, input int stall_at);
        logic [31:0] exp;
        int          la_exp, lb_exp, la, lb, w;
        logic [31:0] ra, rb;
        logic [3:0]  ta, tb_t;
        exp    = ref_result(op, a, b);
        la_exp = ref_lat(op, a, b, 1) + ((stall_at >= 0) ? 3 : 0);
        lb_exp = ref_lat(op, a, b, 2) + ((stall_at >= 0) ? 3 : 0);
        la = -1; lb = -1; ra = '0; rb = '0; ta = '0; tb_t = '0;
        w = 0;
        while (!(a_in_ready && b_in_ready) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("idle_wait", 64'({a_in_ready, b_in_ready}), 64'(2'b11));
        in_valid = 1'b1; in_op = op; v1 = a; v2 = b; tag = t;
        @(negedge clk);
        in_valid = 1'b0; v1 = $urandom; v2 = $urandom; tag = 4'($urandom);
        chk($sformatf("busy_after_accept op%0d", op),
            64'({a_busy, b_busy, a_in_ready, b_in_ready}), 64'(4'b1100));
        for (int k = 0; k < 80 && (la < 0 || lb < 0); k++) begin
            if (k == stall_at) rdy = 1'b0;
            if (k == stall_at + 3) rdy = 1'b1;
            if (a_out_valid && la < 0) begin la = k; ra = a_out_result; ta = a_out_tag; end
            if (b_out_valid && lb < 0) begin lb = k; rb = b_out_result; tb_t = b_out_tag; end
            @(negedge clk);
        end
        rdy = 1'b1;
        chk($sformatf("res_a op%0d %h %h", op, a, b), 64'(ra), 64'(exp));
        chk($sformatf("res_b op%0d %h %h", op, a, b), 64'(rb), 64'(exp));
        chk($sformatf("lat_a op%0d", op), 64'(la), 64'(la_exp));
        chk($sformatf("lat_b op%0d", op), 64'(lb), 64'(lb_exp));
        chk($sformatf("tag_a op%0d", op), 64'(ta), 64'(t));
        chk($sformatf("tag_b op%0d", op), 64'(tb_t), 64'(t));
    endtask

    task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        in_valid = 1'b1; in_op = op; v1 = a; v2 = b; tag = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; v1 = '0; v2 = '0; tag = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_a", 64'({a_in_ready, a_out_valid, a_busy, a_out_result, a_out_tag}),
            64'({1'b1, 1'b0, 1'b0, 32'h0, 4'h0}));
        chk("reset_b", 64'({b_in_ready, b_out_valid, b_busy, b_out_result, b_out_tag}),
            64'({1'b1, 1'b0, 1'b0, 32'h0, 4'h0}));

        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 4'd5, -1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'd3, -1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 4'd4, -1);
        run_op(3'd5, 32'd123,       32'h0,         4'd1, -1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd2, -1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, -1);
        run_op(3'd5, 32'd100,       32'd7,         4'd7, -1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'd6, 5);

        // Flush mid-divide; the dropped quotient must never appear
        offer(3'd4, 32'd1000, 32'd3, 4'd9);
        for (int i = 0; i < 10; i++) begin
            chk("no_valid_before_clear", 64'({a_out_valid, b_out_valid}), 64'(2'b00));
            @(negedge clk);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("after_clear", 64'({a_in_ready, b_in_ready, a_out_valid, b_out_valid}), 64'(4'b1100));
        run_op(3'd0, 32'd7, 32'd6, 4'd10, -1);

        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        offer(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_a", 64'({a_out_valid, a_in_ready, a_out_result}), 64'({1'b1, 1'b0, 32'hFFFF_FFFE}));
            chk("hold_b", 64'({b_out_valid, b_in_ready, b_out_result}), 64'({1'b1, 1'b0, 32'hFFFF_FFFE}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release", 64'({a_in_ready, b_in_ready, a_out_valid, b_out_valid}), 64'(4'b1100));

        // Reset mid-divide
        offer(3'd5, 32'd1000, 32'd3, 4'd12);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_a", 64'({a_in_ready, a_out_valid, a_busy}), 64'(3'b100));
        chk("rst_mid_b", 64'({b_in_ready, b_out_valid, b_busy}), 64'(3'b100));
        run_op(3'd5, 32'd100, 32'd7, 4'd13, -1);

        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 4'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
